// File: rtl/rc4_ksa.sv
// ---------------------------------------------------------------------------
// rc4_ksa - RC4 key-scheduling stage.
//
// Fills the shared 256x8 S memory for the downstream PRGA/decrypt stage:
//   INIT  : s[i] = i for i = 0..255
//   loop  : j = j + s[i] + key[i mod KEY_LENGTH]; swap(s[i], s[j])
// While busy it owns the memory port (ksa_mem_handler=1). It then parks in
// DONE with finish=1 until reset or a new start request.
//
// Handshake: start_sig is a level sampled at the rising edge only while the
// FSM is in IDLE or DONE. A sample of 1 is the acceptance: secret_key is
// latched on that same edge. There is no ready; requests in other states are
// dropped.
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous, active-high
//   start_sig       start request (see handshake above)
//   secret_key      key, byte0 = MSB byte
//   q_data          S-memory read data, READ_LATENCY clocks after address
//   address/data    S-memory address / write data
//   wen             S-memory write enable, one clock per write
//   ksa_mem_handler high while this block owns the S-memory mux
//   finish          high while in DONE
//   dbg_state       current FSM state, for observation only
//   ksa_cycles      busy-cycle count (only with RC4_KSA_CYCLE_COUNT_EN)
//
// Optional feature macro: RC4_KSA_CYCLE_COUNT_EN adds the ksa_cycles port and
// its saturating counter. Without it the port and counter are absent.
//
// All outputs are decoded from registered state only; q_data feeds only
// registers, so there is no combinational path from q_data to any output.
// ---------------------------------------------------------------------------
module rc4_ksa #(
    parameter int KEY_LENGTH   = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_sig,
    input  logic [KEY_LENGTH*8-1:0] secret_key,
    input  logic [7:0]              q_data,
    output logic [7:0]              address,
    output logic [7:0]              data,
    output logic                    wen,
    output logic                    ksa_mem_handler,
    output logic                    finish,
    output logic [3:0]              dbg_state
`ifdef RC4_KSA_CYCLE_COUNT_EN
    ,
    output logic [15:0]             ksa_cycles
`endif
);

    localparam int KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam int LAT_W  = 2;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_INIT = 4'd1,
        S_RD_I = 4'd2,
        S_WT_I = 4'd3,
        S_RD_J = 4'd4,
        S_WT_J = 4'd5,
        S_WR_I = 4'd6,
        S_WR_J = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [7:0]                r_i;
    logic [7:0]                r_j;
    logic [7:0]                r_si;
    logic [7:0]                r_sj;
    logic [KEY_LENGTH*8-1:0]   r_key;
    logic [KIDX_W-1:0]         r_kidx;    // tracks i mod KEY_LENGTH without a divider
    logic [LAT_W-1:0]          r_lat;     // cycles spent in the current WT_* state
    logic                      w_lat_last;
    logic                      w_accept;
    logic [7:0]                w_key_byte;

    assign w_lat_last = (r_lat == LAT_W'(READ_LATENCY - 1));
    assign w_accept   = start_sig && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign dbg_state  = r_state;

    always_comb begin
        w_key_byte = '0;
        for (int k = 0; k < KEY_LENGTH; k++) begin
            if (r_kidx == KIDX_W'(k)) begin
                w_key_byte = r_key[8*(KEY_LENGTH-1-k) +: 8];
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next_state    = r_state;
        address         = 8'd0;
        data            = 8'd0;
        wen             = 1'b0;
        ksa_mem_handler = 1'b0;
        finish          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_sig) w_next_state = S_INIT;
            end
            S_INIT: begin
                ksa_mem_handler = 1'b1;
                address         = r_i;
                data            = r_i;
                wen             = 1'b1;
                if (r_i == 8'hFF) w_next_state = S_RD_I;
            end
            S_RD_I: begin
                ksa_mem_handler = 1'b1;
                address         = r_i;
                w_next_state    = S_WT_I;
            end
            S_WT_I: begin
                ksa_mem_handler = 1'b1;
                address         = r_i;
                if (w_lat_last) w_next_state = S_RD_J;
            end
            S_RD_J: begin
                ksa_mem_handler = 1'b1;
                address         = r_j;
                w_next_state    = S_WT_J;
            end
            S_WT_J: begin
                ksa_mem_handler = 1'b1;
                address         = r_j;
                if (w_lat_last) w_next_state = S_WR_I;
            end
            S_WR_I: begin
                ksa_mem_handler = 1'b1;
                address         = r_i;
                data            = r_sj;
                wen             = 1'b1;
                w_next_state    = S_WR_J;
            end
            S_WR_J: begin
                ksa_mem_handler = 1'b1;
                address         = r_j;
                data            = r_si;
                wen             = 1'b1;
                w_next_state    = (r_i == 8'hFF) ? S_DONE : S_RD_I;
            end
            S_DONE: begin
                finish = 1'b1;
                if (start_sig) w_next_state = S_INIT;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_si    <= 8'd0;
            r_sj    <= 8'd0;
            r_key   <= '0;
            r_kidx  <= '0;
            r_lat   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_sig) begin
                        r_key  <= secret_key;
                        r_i    <= 8'd0;
                        r_j    <= 8'd0;
                        r_kidx <= '0;
                        r_lat  <= '0;
                    end
                end
                S_INIT: r_i <= r_i + 8'd1;    // 255 wraps to 0 for the loop
                S_RD_I, S_RD_J: r_lat <= '0;
                S_WT_I: begin
                    if (w_lat_last) begin
                        r_si  <= q_data;
                        r_j   <= r_j + q_data + w_key_byte;
                        r_lat <= '0;
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                S_WT_J: begin
                    if (w_lat_last) begin
                        r_sj  <= q_data;
                        r_lat <= '0;
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                S_WR_J: begin
                    r_i    <= r_i + 8'd1;
                    r_kidx <= (r_kidx == KIDX_W'(KEY_LENGTH - 1)) ? '0 : r_kidx + KIDX_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef RC4_KSA_CYCLE_COUNT_EN
    logic [15:0] r_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycles <= 16'd0;
        end else if (w_accept) begin
            r_cycles <= 16'd0;
        end else if ((r_state != S_IDLE) && (r_state != S_DONE) && (r_cycles != 16'hFFFF)) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign ksa_cycles = r_cycles;
`else
    logic w_accept_unused;
    assign w_accept_unused = w_accept;
`endif

endmodule

// File: tb/tb_rc4_ksa.sv
module tb_rc4_ksa;
    localparam int RUN_CYCLES = 1792;
    localparam int TIMEOUT    = 3000;

    logic        clk;
    logic        reset;
    logic        start_sig;
    logic [23:0] secret_key;
    logic [7:0]  q_data;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wen;
    logic        ksa_mem_handler;
    logic        finish;
    logic [3:0]  dbg_state;
`ifdef RC4_KSA_CYCLE_COUNT_EN
    logic [15:0] ksa_cycles;
`endif

    rc4_ksa #(.KEY_LENGTH(3), .READ_LATENCY(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_sig       (start_sig),
        .secret_key      (secret_key),
        .q_data          (q_data),
        .address         (address),
        .data            (data),
        .wen             (wen),
        .ksa_mem_handler (ksa_mem_handler),
        .finish          (finish),
        .dbg_state       (dbg_state)
`ifdef RC4_KSA_CYCLE_COUNT_EN
        ,
        .ksa_cycles      (ksa_cycles)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 256x8 RAM with registered address, 1-cycle read latency
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (wen) mem[address] <= data;
        q_data <= mem[address];
    end

    // ---------------- scoreboard ----------------
    int         n_cmp;
    int         n_err;
    logic [7:0] exp_q [$];
    logic [7:0] ref_s [256];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Software RC4 KSA reference
    task automatic sw_ksa(input logic [23:0] key);
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kb;
        for (int i = 0; i < 256; i++) ref_s[i] = 8'(i);
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            kb = key[8*(2 - (i % 3)) +: 8];
            j = j + ref_s[i] + kb;
            t = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
        end
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(ref_s[i]);
    endtask

    task automatic check_ram(input string name);
        int bad;
        int first_bad;
        logic [7:0] e;
        bad = 0;
        first_bad = -1;
        for (int a = 0; a < 256; a++) begin
            e = exp_q.pop_front();
            if (mem[a] !== e) begin
                bad++;
                if (first_bad < 0) first_bad = a;
            end
        end
        check({name, " ram_bad_bytes"}, bad, 0);
        if (bad != 0) $display("  first differing addr %0d", first_bad);
    endtask

    // ---------------- driver ----------------
    // Starts a run at the current negedge and follows it to DONE.
    // noise=1 injects ignored start pulses (with a different key) in RD_I and WT_J.
    task automatic run_vector(input string name, input logic [23:0] key, input bit noise,
                              input logic [7:0] w0a, input logic [7:0] w0d,
                              input logic [7:0] w1a, input logic [7:0] w1d);
        int cyc;
        int hcnt;
        int wr_n;
        int wen_done;
        logic [7:0] a0, d0, a1, d1;
        sw_ksa(key);
        start_sig  = 1'b1;
        secret_key = key;
        @(negedge clk);
        start_sig  = 1'b0;
        secret_key = 24'hA5A5A5;
        check({name, " accept_finish"}, finish, 0);
        check({name, " accept_handler"}, ksa_mem_handler, 1);
        cyc = 0; hcnt = 0; wr_n = 0;
        a0 = 8'hxx; d0 = 8'hxx; a1 = 8'hxx; d1 = 8'hxx;
        while (!finish && cyc < TIMEOUT) begin
            if (ksa_mem_handler) hcnt++;
            if (wen) begin
                wr_n++;
                if (wr_n == 257) begin a0 = address; d0 = data; end
                if (wr_n == 258) begin a1 = address; d1 = data; end
            end
            if (noise && (cyc == 256 || cyc == 259 || cyc == 1000)) begin
                start_sig  = 1'b1;
                secret_key = ~key;
            end else begin
                start_sig  = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start_sig = 1'b0;
        if (!finish) $display("FAIL %s timeout: no finish after %0d cycles", name, cyc);
        check({name, " latency"}, cyc, RUN_CYCLES);
        check({name, " handler_cycles"}, hcnt, RUN_CYCLES);
        check({name, " first_write"}, {a0, d0}, {w0a, w0d});
        check({name, " second_write"}, {a1, d1}, {w1a, w1d});
`ifdef RC4_KSA_CYCLE_COUNT_EN
        check({name, " ksa_cycles"}, ksa_cycles, RUN_CYCLES);
`endif
        check_ram(name);
        // DONE must hold quietly
        wen_done = 0;
        for (int k = 0; k < 110; k++) begin
            if (wen || !finish || ksa_mem_handler) wen_done++;
            @(negedge clk);
        end
        check({name, " done_hold"}, wen_done, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic [23:0] key;
        bit         noise;
        logic [7:0] w0a, w0d, w1a, w1d;   // first two swap-loop writes
    } vec_t;

    vec_t vecs [5];

    initial begin
        int wen_cnt;
        n_cmp = 0;
        n_err = 0;
        // key 0: j=0, s[0]=0 written to addr0 twice
        vecs[0] = '{"key000000", 24'h000000, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        // key byte0=1: j=1, addr0<-1 then addr1<-0
        vecs[1] = '{"key010000", 24'h010000, 1'b0, 8'h00, 8'h01, 8'h01, 8'h00};
        // key byte0=0: same i==j first swap
        vecs[2] = '{"key000249", 24'h000249, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        // key byte0=FF: j wraps to FF
        vecs[3] = '{"keyFFFFFF", 24'hFFFFFF, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00};
        // ignored starts mid-run, byte0=0x12: addr0<-0x12, addr0x12<-0
        vecs[4] = '{"noise123456", 24'h123456, 1'b1, 8'h00, 8'h12, 8'h12, 8'h00};

        reset      = 1'b1;
        start_sig  = 1'b0;
        secret_key = 24'h0;
        repeat (3) @(negedge clk);
        check("reset_address", address, 0);
        check("reset_wen", wen, 0);
        check("reset_finish", finish, 0);
        check("reset_handler", ksa_mem_handler, 0);
        check("reset_state", dbg_state, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_state", dbg_state, 0);

        // successive vectors start from DONE: finish must drop on acceptance
        for (int v = 0; v < 5; v++) begin
            run_vector(vecs[v].name, vecs[v].key, vecs[v].noise,
                       vecs[v].w0a, vecs[v].w0d, vecs[v].w1a, vecs[v].w1d);
        end

        // reset 500 cycles into a run
        start_sig  = 1'b1;
        secret_key = 24'h0BCDEF;
        @(negedge clk);
        start_sig = 1'b0;
        repeat (499) @(negedge clk);
        check("midrun_busy", ksa_mem_handler, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun_reset_outputs", {address, data, wen, ksa_mem_handler, finish}, 0);
        check("midrun_reset_state", dbg_state, 0);
        wen_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            if (wen) wen_cnt++;
            @(negedge clk);
        end
        check("post_reset_no_wen", wen_cnt, 0);
        run_vector("restart000000", 24'h000000, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rc4_ksa.md
Name: rc4_ksa

Overview:
- RC4 key-scheduling stage that fills the shared 256x8 S working memory for the downstream `mem_decrypt` (PRGA/decrypt) stage.
- Phase 1 writes s[i]=i for i=0..255.
- Phase 2 runs the standard KSA swap loop using a 24-bit secret key.
- Owns the S-memory port via `ksa_mem_handler` while busy, then pulses control to the next stage by holding `finish`.

Parameters:
- KEY_LENGTH, 3, number of key bytes; key byte index = i mod KEY_LENGTH.
- READ_LATENCY, 1, clocks from address presentation to valid q_data (on-chip RAM, registered address); legal values 1..3.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_sig  input  1  start request; sampled only in IDLE or DONE.
- secret_key  input  24  key; byte0=[23:16], byte1=[15:8], byte2=[7:0]; captured on start acceptance.
- q_data  input  8  S-memory read data.
- address  output  8  S-memory address.
- data  output  8  S-memory write data.
- wen  output  1  S-memory write enable, one clock per write.
- ksa_mem_handler  output  1  high while this block owns the S-memory mux.
- finish  output  1  high while in DONE.

Behaviour:
- Reset (sync, any state): state=IDLE, i=0, j=0; address=0, data=0, wen=0, ksa_mem_handler=0, finish=0. Reset mid-run abandons the run with no further writes; memory contents are don't-care.
- Start acceptance:
  - start_sig=1 at an edge in IDLE or DONE: latch secret_key, clear i and j, go to INIT, assert ksa_mem_handler, drop finish.
  - start_sig in any other state is ignored.
- INIT (256 cycles): each cycle address=i, data=i, wen=1, then i++. Leaving at i=255 wraps i to 0 and goes to RD_I.
- Swap loop states, i=0..255, all arithmetic mod 256 (8-bit wrap, no carry kept):
  - RD_I (1 cycle): address=i, wen=0.
  - WT_I (READ_LATENCY cycles): address held. On the last cycle: si<=q_data; j<=j+q_data+key[i mod KEY_LENGTH].
  - RD_J (1 cycle): address=j (new j).
  - WT_J (READ_LATENCY cycles): address held. On the last cycle: sj<=q_data.
  - WR_I (1 cycle): address=i, data=sj, wen=1.
  - WR_J (1 cycle): address=j, data=si, wen=1. If i==255 go to DONE, else i++ and go to RD_I.
- i==j case: both writes target the same address with the same value; no special handling needed, and the result must equal a software reference.
- Per iteration = 4+2*READ_LATENCY cycles. Total run = 256 + 256*(4+2*READ_LATENCY) cycles (1792 for READ_LATENCY=1).
- DONE:
  - finish=1, ksa_mem_handler=0, wen=0.
  - Holds until reset, or until start_sig starts a new run (finish drops on the accepting edge).
- Timing: if start is accepted at edge E0, DONE and finish=1 are visible after edge E0+1792 (READ_LATENCY=1).
- Outputs are registered, or decoded purely from registered state; no combinational path from q_data to wen or address.
- wen is never high outside INIT, WR_I and WR_J.

Optional Feature:
- Macro RC4_KSA_CYCLE_COUNT_EN.
- Defined: adds output `ksa_cycles` [15:0]. It clears on start acceptance, increments every cycle not in IDLE/DONE, saturates at 0xFFFF, and holds its value in DONE. Reset clears it. Expected value is 1792 at READ_LATENCY=1.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Bench uses a 256x8 RAM model with 1-cycle read latency.
- Key 0x000000, start pulse → finish after exactly 1792 clocks. Final RAM matches the software KSA for key {00,00,00}. The first loop writes are addr0←0 twice.
- Key 0x010000 → the first swap reads s[0]=0, computes j=1, reads s[1]=1, then writes addr0←1 and addr1←0. Final RAM matches the software model.
- Key 0x000249 → full RAM compare against the software RC4 KSA. ksa_mem_handler is high for exactly 1792 cycles and finish holds high for 100+ idle cycles.
- Reset asserted 500 cycles into a run → next edge shows all outputs at reset values and no wen thereafter. A restart with key 0x000000 then completes correctly.
- start_sig pulsed during RD_I/WT_J of a run → ignored, total latency still 1792. start_sig in DONE with a new key → finish drops on that edge and the new run completes correctly.
- With RC4_KSA_CYCLE_COUNT_EN defined → ksa_cycles=1792 in DONE. With READ_LATENCY=2 → ksa_cycles=2304 and the RAM result is unchanged.
